uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one UART transmitter (legal range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 12*CLOCK_RATE/BAUD_RATE (definitions_pkg), is the maximum number of cycles spent waiting for txDone per byte.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstN  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  high = new grants allowed; low = no new grants, and any byte in flight completes normally.
REQ-006 reqValid  input  NUM_REQ  bit i high = requester i holds a byte to send.
REQ-007 reqData  input  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
REQ-008 reqAccept  output  NUM_REQ  one-hot, one-cycle pulse; reqData[i] is captured in this cycle.
REQ-009 reqDone  output  NUM_REQ  one-hot, one-cycle pulse when requester i's byte has finished, successfully or by timeout.
REQ-010 txData  output  8  byte presented to the UART transmitter.
REQ-011 txStart  output  1  one-cycle start pulse to the UART transmitter.
REQ-012 txEnabled  output  1  transmitter enable; equals registered enable.
REQ-013 txBusy  input  1  UART transmitter busy.
REQ-014 txDone  input  1  UART transmitter byte complete.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 activeId  output  $clog2(NUM_REQ)  index of the requester currently owning the transmitter.
REQ-017 timeoutErr  output  1  one-cycle pulse when a byte is abandoned on timeout.

Function
REQ-018 The state machine SHALL have three states: IDLE, LAUNCH and WAIT_DONE.
REQ-019 IDLE: when enable=1, txBusy=0 and any reqValid bit is set, reqAccept[w] SHALL be driven combinationally in the same cycle, reqData[w] and w SHALL be registered, and the next state SHALL be LAUNCH.
REQ-020 Winner w SHALL be chosen round-robin: search begins at lastGrant+1 and wraps modulo NUM_REQ; lastGrant updates to w on each accept.
REQ-021 LAUNCH SHALL last exactly one cycle, with txStart=1 and txData=the captured byte; the next state SHALL be WAIT_DONE.
REQ-022 txData SHALL hold the captured byte from LAUNCH until the return to IDLE.
REQ-023 WAIT_DONE SHALL count cycles from 0; txDone is sampled only in WAIT_DONE, and a txDone value present during LAUNCH SHALL be ignored.
REQ-024 In WAIT_DONE, txDone=1 SHALL pulse reqDone[activeId] in the next cycle and return the state to IDLE.
REQ-025 If the count reaches TIMEOUT_CYCLES-1 with txDone=0, reqDone[activeId] and timeoutErr SHALL pulse together in the next cycle, and the state SHALL return to IDLE.
REQ-026 If txDone=1 on the terminal count, completion SHALL win and timeoutErr SHALL stay 0.
REQ-027 Accept-to-txStart latency SHALL be 1 cycle, and the earliest re-grant SHALL come 1 cycle after reqDone.
REQ-028 The counter SHALL saturate and never wrap.
REQ-029 A reqValid drop while that requester is in flight SHALL NOT abort the byte.
REQ-030 A deassertion of enable SHALL take effect only in IDLE.

Reset
REQ-031 While rstN=0: state=IDLE, lastGrant=NUM_REQ-1, counter=0, and txStart, txData, txEnabled, reqAccept, reqDone, busy, activeId and timeoutErr all 0.
REQ-032 A reset mid-byte SHALL abandon the byte with no reqDone or timeoutErr pulse; txStart SHALL NOT glitch on reset release.

Verification
REQ-033 Single request: reqValid=0001, reqData[7:0]=8'h5A, enable=1 -> reqAccept=0001 at cycle N, txStart=1 with txData=8'h5A at N+1, txDone at N+10 -> reqDone=0001 at N+11.
REQ-034 All four requesting continuously after reset -> grant order 0,1,2,3,0; no requester is granted twice before the others.
REQ-035 txDone never asserted -> timeoutErr and reqDone[activeId] pulse exactly TIMEOUT_CYCLES+1 cycles after txStart; the next requester is granted 1 cycle later.
REQ-036 txDone asserted on the terminal count -> reqDone pulses, timeoutErr=0.
REQ-037 rstN low during WAIT_DONE -> all outputs 0 within the same cycle; after release with reqValid=0100 -> requester 2 granted, lastGrant sequence restarts.
REQ-038 enable dropped during WAIT_DONE with reqValid=1111 -> the in-flight byte completes with reqDone; no further reqAccept until enable=1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources,
// with a per-byte completion timeout.
//
// state     | meaning
// IDLE      | waiting for a request; grants combinationally when allowed
// LAUNCH    | one-cycle txStart pulse with the captured byte
// WAIT_DONE | counting cycles until txDone or timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CLOCK_RATE     = 50_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int TIMEOUT_CYCLES = 12 * CLOCK_RATE / BAUD_RATE
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           reqValid,
  input  logic [8*NUM_REQ-1:0]         reqData,
  output logic [NUM_REQ-1:0]           reqAccept,
  output logic [NUM_REQ-1:0]           reqDone,
  output logic [7:0]                   txData,
  output logic                         txStart,
  output logic                         txEnabled,
  input  logic                         txBusy,
  input  logic                         txDone,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   activeId,
  output logic                         timeoutErr
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 tx_enabled_q;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic                 timeout_err_q, timeout_err_d;

  logic                 found;
  logic [ID_W-1:0]      win;
  int                   idx;
  logic                 grant;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_grant_q) + off) % NUM_REQ;
      if (!found && reqValid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // No grant in the reqDone cycle: re-grant comes one cycle later.
  assign grant = rstN && (state_q == IDLE) && enable && !txBusy &&
                 (req_done_q == '0) && found;

  assign reqAccept = grant ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_grant_d  = last_grant_q;
    active_id_d   = active_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    req_done_d    = '0;
    timeout_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = LAUNCH;
          tx_data_d    = reqData[8*int'(win) +: 8];
          active_id_d  = win;
          last_grant_d = win;
          tx_start_d   = 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end
      WAIT_DONE: begin
        if (txDone) begin
          req_done_d = NUM_REQ'(1) << active_id_q;
          state_d    = IDLE;
        end else if (cnt_q == TERM_CNT) begin
          req_done_d    = NUM_REQ'(1) << active_id_q;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_grant_q  <= ID_W'(NUM_REQ - 1);
      active_id_q   <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      tx_enabled_q  <= 1'b0;
      req_done_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_grant_q  <= last_grant_d;
      active_id_q   <= active_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      tx_enabled_q  <= enable;
      req_done_q    <= req_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign txData     = tx_data_q;
  assign txStart    = tx_start_q;
  assign txEnabled  = tx_enabled_q;
  assign reqDone    = req_done_q;
  assign timeoutErr = timeout_err_q;
  assign activeId   = active_id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants are queued as stimulus
// is applied and popped when the arbiter accepts a request.
module tb_uart_tx_arbiter;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqAccept;
  logic [3:0]  reqDone;
  logic [7:0]  txData;
  logic        txStart;
  logic        txEnabled;
  logic        txBusy;
  logic        txDone;
  logic        busy;
  logic [1:0]  activeId;
  logic        timeoutErr;

  int checks = 0;
  int errors = 0;

  typedef struct { int id; logic [7:0] data; } exp_t;
  exp_t exp_q[$];

  uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstN(rstN), .enable(enable), .reqValid(reqValid),
    .reqData(reqData), .reqAccept(reqAccept), .reqDone(reqDone),
    .txData(txData), .txStart(txStart), .txEnabled(txEnabled),
    .txBusy(txBusy), .txDone(txDone), .busy(busy), .activeId(activeId),
    .timeoutErr(timeoutErr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstN = 1'b0; reqValid = '0; txDone = 1'b0; txBusy = 1'b0; enable = 1'b1;
    @(posedge clk); #1;
    rstN = 1'b1;
  endtask

  // Waits for the next grant and follows that byte to its reqDone pulse.
  // done_lat < 0 or >= T means txDone never arrives in time (timeout expected).
  task automatic serve(input int done_lat, input bit launch_done,
                       input logic [3:0] clr, input bit drop_en, output int waited);
    exp_t e;
    int   exp_j;
    bit   exp_to;
    bit   seen;
    waited = 0;
    @(negedge clk);
    while (reqAccept === 4'b0 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (reqAccept === 4'b0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL grant_wait: reqAccept=%b queued=%0d", reqAccept, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    if (reqAccept !== 4'(1 << e.id)) begin
      errors++;
      $display("FAIL grant_id: reqAccept=%b expected=%b", reqAccept, 4'(1 << e.id));
    end
    @(posedge clk); #1;
    txDone   = launch_done;
    reqValid = reqValid & ~clr;
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    checks++;
    if (txStart !== 1'b1 || txData !== e.data || activeId !== 2'(e.id) || busy !== 1'b1) begin
      errors++;
      $display("FAIL launch: txStart=%b txData=%h activeId=%0d busy=%b expected 1 %h %0d 1",
               txStart, txData, activeId, busy, e.data, e.id);
    end
    exp_to = !(done_lat >= 0 && done_lat <= T - 1);
    exp_j  = exp_to ? T + 1 : done_lat + 2;
    seen   = 1'b0;
    for (int j = 1; j <= T + 4 && !seen; j++) begin
      @(posedge clk); #1;
      txDone = (j - 1 == done_lat);
      @(negedge clk);
      if (reqDone !== 4'b0 || timeoutErr !== 1'b0) begin
        seen = 1'b1;
        checks++;
        if (j != exp_j || reqDone !== 4'(1 << e.id) || timeoutErr !== exp_to || reqAccept !== 4'b0) begin
          errors++;
          $display("FAIL done: cycle=%0d reqDone=%b timeoutErr=%b reqAccept=%b expected cycle=%0d %b %b 0000",
                   j, reqDone, timeoutErr, reqAccept, exp_j, 4'(1 << e.id), exp_to);
        end
      end
    end
    txDone = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_missing: no reqDone for id %0d, expected at cycle %0d", e.id, exp_j);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; enable = 1'b1; reqValid = 4'hF; txBusy = 1'b0; txDone = 1'b0;
    reqData = 32'hA3A2A1A0;
    repeat (2) @(negedge clk);
    checks++;
    if ({reqAccept, reqDone, txData, txStart, txEnabled, busy, activeId, timeoutErr} !== 22'b0) begin
      errors++;
      $display("FAIL reset_outputs: acc=%b done=%b data=%h start=%b en=%b busy=%b id=%0d to=%b expected all 0",
               reqAccept, reqDone, txData, txStart, txEnabled, busy, activeId, timeoutErr);
    end
    @(posedge clk); #1;
    reqValid = 4'b0; rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (txStart !== 1'b0 || busy !== 1'b0 || reqAccept !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: txStart=%b busy=%b reqAccept=%b expected 0 0 0000", txStart, busy, reqAccept);
    end
    @(negedge clk);
    checks++;
    if (txEnabled !== 1'b1) begin
      errors++;
      $display("FAIL tx_enabled: txEnabled=%b expected 1", txEnabled);
    end
  endtask

  task automatic test_single();
    int w;
    @(posedge clk); #1;
    reqData[7:0] = 8'h5A;
    reqValid     = 4'b0001;
    push_exp(0, 8'h5A);
    serve(8, 1'b0, 4'b0001, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL single_latency: waited=%0d expected 0", w);
    end
  endtask

  task automatic test_round_robin();
    int w;
    int lat[5] = '{3, 0, 5, 1, 2};
    int ids[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    reqData  = 32'hA3A2A1A0;
    reqValid = 4'hF;
    for (int k = 0; k < 5; k++) push_exp(ids[k], 8'hA0 + 8'(ids[k]));
    for (int k = 0; k < 5; k++) begin
      serve(lat[k], k == 0, 4'b0, 1'b0, w);
      checks++;
      if (w != 0) begin
        errors++;
        $display("FAIL rr_back_to_back: grant %0d waited=%0d expected 0", k, w);
      end
    end
  endtask

  task automatic test_timeout();
    int w;
    push_exp(1, 8'hA1);
    serve(-1, 1'b0, 4'b0, 1'b0, w);
    push_exp(2, 8'hA2);
    serve(2, 1'b0, 4'b0, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL regrant_after_timeout: waited=%0d expected 0", w);
    end
    push_exp(3, 8'hA3);
    serve(T - 1, 1'b0, 4'hF, 1'b0, w);
  endtask

  task automatic test_reset_mid_byte();
    int w;
    @(posedge clk); #1;
    reqValid = 4'b0010;
    @(negedge clk);
    checks++;
    if (reqAccept !== 4'b0010) begin
      errors++;
      $display("FAIL mid_grant: reqAccept=%b expected 0010", reqAccept);
    end
    repeat (5) @(posedge clk);
    #1;
    rstN = 1'b0; reqValid = 4'b0101;
    @(negedge clk);
    checks++;
    if ({reqAccept, reqDone, txData, txStart, txEnabled, busy, activeId, timeoutErr} !== 22'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: acc=%b done=%b data=%h start=%b en=%b busy=%b id=%0d to=%b expected all 0",
               reqAccept, reqDone, txData, txStart, txEnabled, busy, activeId, timeoutErr);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    push_exp(0, 8'hA0);
    serve(1, 1'b0, 4'b0001, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL restart_grant: waited=%0d expected 0", w);
    end
    push_exp(2, 8'hA2);
    serve(2, 1'b0, 4'b0100, 1'b0, w);
  endtask

  task automatic test_enable_drop();
    int w;
    @(posedge clk); #1;
    txBusy = 1'b1; reqValid = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (reqAccept !== 4'b0) begin
        errors++;
        $display("FAIL txbusy_block: reqAccept=%b expected 0000", reqAccept);
      end
    end
    @(posedge clk); #1;
    txBusy = 1'b0;
    push_exp(3, 8'hA3);
    serve(5, 1'b0, 4'b0, 1'b1, w);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (reqAccept !== 4'b0 || busy !== 1'b0 || txEnabled !== 1'b0) begin
        errors++;
        $display("FAIL disabled_idle: reqAccept=%b busy=%b txEnabled=%b expected 0000 0 0",
                 reqAccept, busy, txEnabled);
      end
    end
    @(posedge clk); #1;
    enable = 1'b1;
    push_exp(0, 8'hA0);
    serve(1, 1'b0, 4'hF, 1'b0, w);
    checks++;
    if (w != 0) begin
      errors++;
      $display("FAIL reenable_grant: waited=%0d expected 0", w);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_reset_mid_byte();
    test_enable_drop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
